btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//  Input stage between the board push-buttons and the game core that drives the VGA output.
//  Each raw button goes through a 2-FF synchroniser and a debouncer.
//  The block turns left/right into gated move levels.
//  It turns jump into a charge-and-release event: a one-cycle fire pulse plus a saturating power value.
// PARAMETERS
//  DEBOUNCE_CYCLES     1_000_000  consecutive stable cycles before a debounced level flips (10 ms @100 MHz)
//  CHARGE_STEP_CYCLES  2_500_000  cycles of held jump per +1 power step (25 ms @100 MHz)
//  PWR_W               5          width of jump_power
//  PWR_MAX             31         power saturation value, must be <= 2**PWR_W-1
// PORTS
//  sys_clk        in   1      system clock, 100 MHz
//  sys_rst_n      in   1      asynchronous active-low reset
//  left_btn       in   1      raw left button, asynchronous, active-high
//  right_btn      in   1      raw right button, asynchronous, active-high
//  jump_btn       in   1      raw jump button, asynchronous, active-high
//  move_left      out  1      registered level: move left requested
//  move_right     out  1      registered level: move right requested
//  jump_charging  out  1      registered level: jump is being charged
//  jump_fire      out  1      registered one-cycle pulse on jump release
//  jump_power     out  PWR_W  registered charge level, valid while jump_fire=1
// BEHAVIOUR
//  Reset: all sync flops, debounced levels, counters and outputs go to 0; FSM goes to IDLE.
//  Sync: 2 flops per button, reset value 0.
//  Debounce (per button)
//   - Counter increments while sync != db, and clears to 0 when sync == db.
//   - When the counter reaches DEBOUNCE_CYCLES-1 and the input still differs: db toggles and the counter clears.
//   - Net latency, raw edge to db edge: 2 + DEBOUNCE_CYCLES cycles.
//   - Glitch shorter than DEBOUNCE_CYCLES cycles: no change.
//  Move outputs (registered, +1 cycle after db)
//   - move_left  = left_db  & ~right_db & (state==IDLE)
//   - move_right = right_db & ~left_db  & (state==IDLE)
//   - Both held -> both outputs 0.
//   - Movement is masked during CHARGE and FIRE.
//  Jump FSM, states IDLE / CHARGE / FIRE (2-bit)
//   - IDLE: on jump_db 0->1 go to CHARGE; clear jump_power and step_cnt.
//   - CHARGE:
//       * jump_charging=1; step_cnt increments.
//       * At step_cnt==CHARGE_STEP_CYCLES-1: step_cnt wraps to 0 and jump_power increments, saturating at PWR_MAX (no wrap).
//       * On jump_db 1->0 go to FIRE.
//   - FIRE: jump_fire=1 for exactly one cycle; jump_power frozen; next state IDLE unconditionally.
//   - A jump_db rise seen while in FIRE is ignored; the next charge needs a new 0->1 edge in IDLE.
//   - jump_power keeps its last value in IDLE until the next CHARGE entry clears it.
//   - Release on the same cycle as a step boundary: that step's increment is applied, then FIRE.
//   - Reset mid-charge: jump_fire is never emitted and power returns to 0.
//  Counter widths are $clog2(param) bits; no combinational path from input to output.
// STRUCTURE
//  Shared package game_pkg:
//   - jump FSM state localparams (ST_IDLE=0, ST_CHARGE=1, ST_FIRE=2)
//   - PWR_W / PWR_MAX defaults, so the game core sizes jump velocity tables consistently
//  Sub-module btn_debounce (params DEBOUNCE_CYCLES):
//   - contains the sync flops and debounce counter
//   - ports sys_clk, sys_rst_n, raw, db
//   - instantiated 3 times
//  The top of this block holds only the move gating and the jump FSM.
// TESTING (bench overrides: DEBOUNCE_CYCLES=4, CHARGE_STEP_CYCLES=8, PWR_W=3, PWR_MAX=7; 10 ns clock)
//  1 Hold sys_rst_n=0 for 3 cycles with buttons toggling -> all outputs 0, jump_power=0.
//  2 left_btn pulsed high for 3 cycles, then low -> move_left stays 0 for 50 cycles.
//  3 left_btn held high -> move_left rises exactly 7 edges later (2 sync + 4 debounce + 1 reg).
//    Then add right_btn -> both 0 after 7 edges.
//  4 jump_btn held (db high) for 40 cycles, then released:
//    -> jump_charging=1 throughout and move_* forced 0
//    -> after release, one jump_fire pulse with jump_power=5, then IDLE
//  5 jump_btn held 200 cycles -> jump_power saturates at 7 (no wrap); release -> single fire with power 7.
//  6 Assert sys_rst_n=0 mid-CHARGE (power=3) -> immediate power=0, charging=0, no jump_fire after reset release.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions between the button conditioner and the game core.
// Jump power width/cap live here so velocity tables stay sized consistently.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHARGE = 2'd1,
        ST_FIRE   = 2'd2
    } jump_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT    = 1_000_000;
    localparam int CHARGE_STEP_CYCLES_DEFAULT = 2_500_000;
    localparam int PWR_W_DEFAULT              = 5;
    localparam int PWR_MAX_DEFAULT            = 31;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one raw button.
// Raw edge reaches db after 2 + DEBOUNCE_CYCLES cycles; shorter glitches are dropped.
module btn_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic raw,
    output logic db
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            // Any cycle where the synced input agrees with db restarts the count.
            if (r_sync2 != r_db) begin
                if (r_cnt == CNT_LAST) begin
                    r_db  <= ~r_db;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign db = r_db;

endmodule

// File: rtl/btn_conditioner.sv
// Debounced buttons to gated move levels and a charge-and-release jump (fire pulse + power).
// All outputs registered: move one cycle after db, fire one cycle after the jump db falls.
module btn_conditioner
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CHARGE_STEP_CYCLES = CHARGE_STEP_CYCLES_DEFAULT,
    parameter int PWR_W              = PWR_W_DEFAULT,
    parameter int PWR_MAX            = PWR_MAX_DEFAULT
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             left_btn,
    input  logic             right_btn,
    input  logic             jump_btn,
    output logic             move_left,
    output logic             move_right,
    output logic             jump_charging,
    output logic             jump_fire,
    output logic [PWR_W-1:0] jump_power
);

    localparam int SW = (CHARGE_STEP_CYCLES > 1) ? $clog2(CHARGE_STEP_CYCLES) : 1;
    localparam logic [SW-1:0]    STEP_LAST = SW'(CHARGE_STEP_CYCLES - 1);
    localparam logic [PWR_W-1:0] PWR_CAP   = PWR_W'(PWR_MAX);

    logic w_left_db;
    logic w_right_db;
    logic w_jump_db;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .raw(left_btn), .db(w_left_db)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .raw(right_btn), .db(w_right_db)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_jump (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .raw(jump_btn), .db(w_jump_db)
    );

    jump_state_t      r_state;
    jump_state_t      w_state_nxt;
    logic             r_jump_db_d;
    logic [SW-1:0]    r_step;
    logic [SW-1:0]    w_step_nxt;
    logic [PWR_W-1:0] r_power;
    logic [PWR_W-1:0] w_power_nxt;
    logic             r_move_left;
    logic             r_move_right;
    logic             r_charging;
    logic             r_fire;

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_power_nxt = r_power;
        case (r_state)
            ST_IDLE: begin
                // Only a fresh rise counts; a level left high through FIRE does not retrigger.
                if (w_jump_db && !r_jump_db_d) begin
                    w_state_nxt = ST_CHARGE;
                    w_step_nxt  = '0;
                    w_power_nxt = '0;
                end
            end
            ST_CHARGE: begin
                if (r_step == STEP_LAST) begin
                    w_step_nxt = '0;
                    if (r_power != PWR_CAP) begin
                        w_power_nxt = r_power + PWR_W'(1);
                    end
                end else begin
                    w_step_nxt = r_step + SW'(1);
                end
                if (!w_jump_db) begin
                    w_state_nxt = ST_FIRE;
                end
            end
            ST_FIRE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= ST_IDLE;
            r_jump_db_d  <= 1'b0;
            r_step       <= '0;
            r_power      <= '0;
            r_move_left  <= 1'b0;
            r_move_right <= 1'b0;
            r_charging   <= 1'b0;
            r_fire       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_jump_db_d  <= w_jump_db;
            r_step       <= w_step_nxt;
            r_power      <= w_power_nxt;
            r_move_left  <= w_left_db & ~w_right_db & (r_state == ST_IDLE);
            r_move_right <= w_right_db & ~w_left_db & (r_state == ST_IDLE);
            r_charging   <= (w_state_nxt == ST_CHARGE);
            r_fire       <= (w_state_nxt == ST_FIRE);
        end
    end

    assign move_left     = r_move_left;
    assign move_right    = r_move_right;
    assign jump_charging = r_charging;
    assign jump_fire     = r_fire;
    assign jump_power    = r_power;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with small debounce/charge parameters.
// Expected fire powers are queued at release and consumed when jump_fire appears.
module tb_btn_conditioner;

    localparam int PW = 3;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          left_btn  = 1'b0;
    logic          right_btn = 1'b0;
    logic          jump_btn  = 1'b0;
    logic          move_left;
    logic          move_right;
    logic          jump_charging;
    logic          jump_fire;
    logic [PW-1:0] jump_power;

    int            tests = 0;
    int            fails = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp_pw;

    always #5 sys_clk = ~sys_clk;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CHARGE_STEP_CYCLES(8),
        .PWR_W(PW),
        .PWR_MAX(7)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .left_btn(left_btn),
        .right_btn(right_btn),
        .jump_btn(jump_btn),
        .move_left(move_left),
        .move_right(move_right),
        .jump_charging(jump_charging),
        .jump_fire(jump_fire),
        .jump_power(jump_power)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every fire pulse cycle must match one queued release, in order.
    always @(negedge sys_clk) begin
        if (jump_fire === 1'b1) begin
            tests++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL fire_unexpected observed=fire(power=%0d) expected=no_fire", jump_power);
            end
            if (exp_q.size() > 0) begin
                exp_pw = exp_q.pop_front();
                tests++;
                assert (jump_power === exp_pw) else begin
                    fails++;
                    $error("FAIL fire_power observed=%0d expected=%0d", jump_power, exp_pw);
                end
            end
        end
    end

    initial begin
        // 1: reset held with buttons toggling
        for (int i = 0; i < 3; i++) begin
            left_btn  = ~left_btn;
            right_btn = ~right_btn;
            jump_btn  = ~jump_btn;
            tick(1);
        end
        check("rst_move_left", move_left, 0);
        check("rst_move_right", move_right, 0);
        check("rst_charging", jump_charging, 0);
        check("rst_fire", jump_fire, 0);
        check("rst_power", jump_power, 0);
        left_btn  = 1'b0;
        right_btn = 1'b0;
        jump_btn  = 1'b0;
        tick(1);
        sys_rst_n = 1'b1;
        tick(10);
        check("idle_move_left", move_left, 0);

        // 2: 3-cycle glitch on left is swallowed
        left_btn = 1'b1;
        tick(3);
        left_btn = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check("glitch_move_left", move_left, 0);
        end

        // 3: left held -> move_left after exactly 7 edges; adding right cancels
        left_btn = 1'b1;
        tick(6);
        check("left_edge6", move_left, 0);
        tick(1);
        check("left_edge7", move_left, 1);
        check("left_only_right", move_right, 0);
        right_btn = 1'b1;
        tick(6);
        check("both_edge6_left", move_left, 1);
        tick(1);
        check("both_edge7_left", move_left, 0);
        check("both_edge7_right", move_right, 0);
        right_btn = 1'b0;
        tick(10);
        check("left_again", move_left, 1);

        // 4: jump held 40 cycles while left held -> power 5 on release
        jump_btn = 1'b1;
        for (int i = 1; i <= 49; i++) begin
            tick(1);
            if (i == 40) begin
                jump_btn = 1'b0;
                exp_q.push_back(3'd5);
            end
            if (i >= 8 && i <= 46) begin
                check("chg_charging", jump_charging, 1);
                check("chg_move_left", move_left, 0);
                check("chg_move_right", move_right, 0);
            end
            if (i == 47) begin
                check("fire_pulse", jump_fire, 1);
                check("fire_not_charging", jump_charging, 0);
            end
            if (i == 48) check("fire_one_cycle", jump_fire, 0);
            if (i == 49) check("move_after_fire", move_left, 1);
        end
        left_btn = 1'b0;
        tick(20);
        check("jump1_fired", 8'(exp_q.size()), 0);
        check("idle_power_kept", jump_power, 5);

        // 5: long hold saturates at 7
        jump_btn = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            tick(1);
            if (i == 100) check("sat_mid_power", jump_power, 7);
            if (i == 100) check("sat_mid_charging", jump_charging, 1);
        end
        check("sat_end_power", jump_power, 7);
        jump_btn = 1'b0;
        exp_q.push_back(3'd7);
        tick(20);
        check("jump2_fired", 8'(exp_q.size()), 0);

        // 6: reset during charge at power 3
        jump_btn = 1'b1;
        begin
            int k;
            k = 0;
            while (jump_power !== 3'd3 && k < 100) begin
                tick(1);
                k++;
            end
        end
        check("reach_power3", jump_power, 3);
        sys_rst_n = 1'b0;
        jump_btn  = 1'b0;
        #1;
        check("midrst_power", jump_power, 0);
        check("midrst_charging", jump_charging, 0);
        check("midrst_fire", jump_fire, 0);
        tick(3);
        sys_rst_n = 1'b1;
        tick(50);
        check("postrst_power", jump_power, 0);
        check("postrst_charging", jump_charging, 0);
        check("queue_empty", 8'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
